edge_result_writer: RTL and testbench
=====================================

Name: edge_result_writer

Overview:
- Downstream stage of the edge-detection accelerator datapath.
- Consumes the stream of 8-bit edge-magnitude pixels from the Sobel compute stage.
- Packs four pixels into each 32-bit word and writes the words into the result region of the shared image memory (word-addressed, 16-bit address).
- Arbitrates for the memory port through a req/gnt handshake and signals frame completion, which drives the accelerator's finish.

Parameters:
IMG_W, 352, image width in pixels; must be a multiple of 4
IMG_H, 288, image height in pixels
WR_BASE, 25344, word address of the first result word (IMG_W*IMG_H/4)
ADDR_W, 16, memory address width

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-low reset
start  in  1  frame start pulse; clears counters and arms the block
pix_valid  in  1  upstream pixel valid
pix_data  in  8  edge pixel value, raster order
pix_ready  out  1  block accepts pix_data this cycle
wr_req  out  1  request for the memory port
wr_gnt  in  1  memory port granted this cycle
addr  out  ADDR_W  memory word address
dataW  out  32  packed write data
en  out  1  memory enable
we  out  1  memory write enable
words_written  out  ADDR_W  count of committed result words
frame_done  out  1  all words of the frame committed; level signal

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; byte_cnt=0; word_idx=0; pend_valid=0; pix_ready=0; wr_req=0; en=0; we=0; addr=0; dataW=0; words_written=0; frame_done=0.
- States: IDLE, RUN, DONE.
  - IDLE --start=1--> RUN.
  - RUN --last word committed--> DONE.
  - DONE --start=1--> RUN.
  - start in RUN is ignored.
  - Entering RUN clears byte_cnt, word_idx, words_written, pend_valid and frame_done.
- Accept: a pixel transfers on a cycle with pix_valid && pix_ready.
- Packing: pixel k of each group lands in bits [8k+7:8k] (k = byte_cnt 0..3; first pixel in the LSBs). byte_cnt increments mod 4 on each transfer.
- Pending word:
  - The 4th transfer of a group moves {pix_data, bytes 2..0} into the pending register, sets pend_valid and latches pend_addr = WR_BASE + word_idx.
  - word_idx increments on that same transfer.
- pix_ready = (state==RUN) && !(byte_cnt==3 && pend_valid && !commit). A 4th byte is accepted in the same cycle the previous pending word commits; there are no bubbles at full rate.
- Write port:
  - wr_req = pend_valid.
  - commit = pend_valid && wr_gnt.
  - en = we = commit (combinational).
  - addr = pend_addr and dataW = pending word, held stable while pend_valid; both are 0 otherwise.
  - Memory samples the write at the rising edge ending the commit cycle.
- On commit: words_written increments. pend_valid clears unless a new word is loaded in the same cycle, in which case it stays 1 with new contents.
- Completion:
  - Total words = IMG_W*IMG_H/4 (25344 by default).
  - On the commit cycle of word 25343, state goes to DONE and frame_done=1 from the next cycle. frame_done holds until the next start.
  - In DONE, pix_ready=0 and no further writes are issued.
- Backpressure: while wr_gnt=0 and a word is pending, up to three further pixels are accepted, then pix_ready drops. No data is lost or duplicated.
- Address arithmetic: WR_BASE + word_idx, truncated to ADDR_W. WR_BASE + total words must not exceed 2^ADDR_W; overflow is not checked.
- Reset mid-frame: everything is abandoned immediately, en/we deassert asynchronously, and no partial word is written.
- pix_valid outside RUN is ignored and is not counted.

Test Plan:
- Full-rate stream: start, then pixels 0x00,0x01,... continuously with wr_gnt=1 -> word 0 = 0x03020100 at addr 25344, word 1 = 0x07060504 at 25345; one write every 4 cycles; pix_ready never drops.
- Grant stall: hold wr_gnt=0 for 10 cycles after the first word pends -> exactly 3 more pixels accepted, then pix_ready=0; on gnt=1 the writes occur in order with correct data; no pixel lost.
- Same-cycle commit and load: wr_gnt rises on the cycle the 4th byte of the next group arrives -> both the commit and the new pending word happen; pend_valid stays 1.
- Frame end: small config IMG_W=8, IMG_H=2 -> exactly 4 writes at WR_BASE..WR_BASE+3; frame_done=1 the cycle after the 4th commit; extra pix_valid is ignored; words_written=4.
- Restart: start in DONE -> frame_done=0, words_written=0, the next word goes to WR_BASE again. start pulsed mid-RUN -> no effect.
- Async reset mid-frame: assert reset=0 between clock edges with a word pending -> en/we drop immediately, all outputs at reset values, and no write occurs after release until a new start.

Source files
------------

// File: rtl/edge_result_writer_if.sv
// ---------------------------------------------------------------------------
// edge_result_writer_if
// Pixel stream in, memory write port out, bundled for edge_result_writer.
//   pix_valid / pix_data / pix_ready : upstream edge-pixel stream
//   wr_req / wr_gnt                  : memory port arbitration
//   addr / dataW / en / we           : word write into shared image memory
// master : writer side (consumes pixels, drives the memory write)
// slave  : environment side (pixel source, arbiter and memory)
// ---------------------------------------------------------------------------
interface edge_result_writer_if #(
   parameter int ADDR_W = 16
);
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              pix_ready;
   logic              wr_req;
   logic              wr_gnt;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       dataW;
   logic              en;
   logic              we;

   modport master (
      input  pix_valid, pix_data, wr_gnt,
      output pix_ready, wr_req, addr, dataW, en, we
   );

   modport slave (
      output pix_valid, pix_data, wr_gnt,
      input  pix_ready, wr_req, addr, dataW, en, we
   );
endinterface

// File: rtl/edge_result_writer.sv
// ---------------------------------------------------------------------------
// edge_result_writer
// Packs 8-bit edge pixels four to a 32-bit word (first pixel in the LSBs) and
// writes the words to WR_BASE.. in shared memory through a req/gnt port.
// Raises frame_done once every word of the frame has been committed.
//   clk, reset (async, active low), start (frame start pulse)
//   bus            : pixel stream + memory write port (master side)
//   words_written  : committed word count for the current frame
//   frame_done     : level, set after the last commit until next start
// ---------------------------------------------------------------------------
module edge_result_writer #(
   parameter int IMG_W   = 352,
   parameter int IMG_H   = 288,
   parameter int ADDR_W  = 16,
   parameter int WR_BASE = IMG_W * IMG_H / 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   edge_result_writer_if.master bus,
   output logic [ADDR_W-1:0]    words_written,
   output logic                 frame_done
);
   localparam int                TOTAL     = IMG_W * IMG_H / 4;
   localparam logic [ADDR_W-1:0] TOTAL_W   = ADDR_W'(TOTAL);
   localparam logic [ADDR_W-1:0] LAST_W    = ADDR_W'(TOTAL - 1);
   localparam logic [ADDR_W-1:0] WR_BASE_W = ADDR_W'(WR_BASE);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       bytes_q, bytes_d;       // pixels 0..2 of the open group
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic              pend_valid_q, pend_valid_d;
   logic [31:0]       pend_data_q, pend_data_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [ADDR_W-1:0] words_q, words_d;
   logic              frame_done_q, frame_done_d;

   logic commit;
   logic pix_ready;
   logic xfer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         bytes_q      <= '0;
         word_idx_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         pend_addr_q  <= '0;
         words_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         bytes_q      <= bytes_d;
         word_idx_q   <= word_idx_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         pend_addr_q  <= pend_addr_d;
         words_q      <= words_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      bytes_d      = bytes_q;
      word_idx_d   = word_idx_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      pend_addr_d  = pend_addr_q;
      words_d      = words_q;
      frame_done_d = frame_done_q;

      commit    = pend_valid_q && bus.wr_gnt;
      // The 4th byte may only enter if the pending slot frees this cycle.
      pix_ready = (state_q == RUN) &&
                  !(byte_cnt_q == 2'd3 && pend_valid_q && !commit);
      xfer      = bus.pix_valid && pix_ready;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = RUN;
               byte_cnt_d   = '0;
               word_idx_d   = '0;
               words_d      = '0;
               pend_valid_d = 1'b0;
               frame_done_d = 1'b0;
            end
         end
         RUN: begin
            if (commit) begin
               pend_valid_d = 1'b0;
               words_d      = words_q + 1'b1;
            end
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: bytes_d[7:0]   = bus.pix_data;
                  2'd1: bytes_d[15:8]  = bus.pix_data;
                  2'd2: bytes_d[23:16] = bus.pix_data;
                  default: begin
                     // Surplus pixels past the frame's last word are dropped.
                     if (word_idx_q != TOTAL_W) begin
                        pend_valid_d = 1'b1;
                        pend_data_d  = {bus.pix_data, bytes_q};
                        pend_addr_d  = WR_BASE_W + word_idx_q;
                        word_idx_d   = word_idx_q + 1'b1;
                     end
                  end
               endcase
            end
            if (commit && words_q == LAST_W) begin
               state_d      = DONE;
               frame_done_d = 1'b1;
               pend_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.pix_ready = pix_ready;
   assign bus.wr_req    = pend_valid_q;
   assign bus.en        = commit;
   assign bus.we        = commit;
   assign bus.addr      = pend_valid_q ? pend_addr_q : '0;
   assign bus.dataW     = pend_valid_q ? pend_data_q : '0;
   assign words_written = words_q;
   assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_edge_result_writer.sv
module tb_edge_result_writer;
   localparam int AW   = 16;
   localparam int BASE = 25344;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] words_written;
   logic          frame_done;

   edge_result_writer_if #(.ADDR_W(AW)) bus ();

   // Small frame: 8x2 pixels -> 4 words, written at BASE..BASE+3.
   edge_result_writer #(.IMG_W(8), .IMG_H(2), .ADDR_W(AW), .WR_BASE(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .words_written(words_written), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   logic [AW-1:0] wa[$];
   logic [31:0]   wd[$];
   int            wc[$];

   // Memory side: capture every committed write with its cycle number.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.en && bus.we) begin
         wa.push_back(bus.addr);
         wd.push_back(bus.dataW);
         wc.push_back(cyc);
      end
   end

   task automatic test_reset();
      bus.pix_valid = 1'b1; bus.pix_data = 8'h55; bus.wr_gnt = 1'b1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      nvec++;
      if ({bus.pix_ready, bus.wr_req, bus.en, bus.we, bus.addr, bus.dataW, words_written, frame_done} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got rdy=%b req=%b en=%b we=%b addr=%0h data=%0h ww=%0d fd=%b, want all 0",
                  bus.pix_ready, bus.wr_req, bus.en, bus.we, bus.addr, bus.dataW, words_written, frame_done);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if (bus.pix_ready !== 1'b0 || bus.wr_req !== 1'b0) begin
         nerr++;
         $display("FAIL idle_ignores_pix: got rdy=%b req=%b, want 0 0", bus.pix_ready, bus.wr_req);
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic test_full_rate();
      logic [31:0] exp_d [4] = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
      int base = wa.size();
      int drops = 0;
      start = 1'b1; bus.wr_gnt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(i);
         #1 if (bus.pix_ready !== 1'b1) drops++;
         @(negedge clk);
      end
      bus.pix_valid = 1'b0;
      nvec++;
      if (drops !== 0) begin nerr++; $display("FAIL full_rate_ready: got %0d drops, want 0", drops); end
      nvec++;
      if (frame_done !== 1'b0 || wa.size() !== base + 3) begin
         nerr++; $display("FAIL pre_last_commit: got fd=%b writes=%0d, want 0 3", frame_done, wa.size() - base);
      end
      for (int t = 0; t < 20 && wa.size() < base + 4; t++) @(negedge clk);
      nvec++;
      if (wa.size() !== base + 4) begin
         nerr++; $display("FAIL full_rate_count: got %0d writes, want 4", wa.size() - base);
      end else begin
         nvec++;
         if (frame_done !== 1'b1) begin nerr++; $display("FAIL frame_done_next: got %b, want 1", frame_done); end
         for (int i = 0; i < 4; i++) begin
            nvec++;
            if (wa[base+i] !== AW'(BASE + i) || wd[base+i] !== exp_d[i]) begin
               nerr++; $display("FAIL full_rate_word%0d: got %0d/%h, want %0d/%h", i, wa[base+i], wd[base+i], BASE + i, exp_d[i]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            nvec++;
            if (wc[base+i+1] - wc[base+i] !== 4) begin
               nerr++; $display("FAIL full_rate_spacing%0d: got %0d cycles, want 4", i, wc[base+i+1] - wc[base+i]);
            end
         end
      end
      nvec++;
      if (words_written !== AW'(4)) begin nerr++; $display("FAIL full_rate_ww: got %0d, want 4", words_written); end
   endtask

   task automatic test_done_ignores();
      int base = wa.size();
      int rdy = 0;
      for (int i = 0; i < 6; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'hee; bus.wr_gnt = 1'b1;
         #1 if (bus.pix_ready !== 1'b0) rdy++;
         @(negedge clk);
      end
      bus.pix_valid = 1'b0;
      nvec++;
      if (rdy !== 0 || wa.size() !== base) begin
         nerr++; $display("FAIL done_ignores: got rdy_cycles=%0d writes=%0d, want 0 0", rdy, wa.size() - base);
      end
      nvec++;
      if (frame_done !== 1'b1 || words_written !== AW'(4)) begin
         nerr++; $display("FAIL done_holds: got fd=%b ww=%0d, want 1 4", frame_done, words_written);
      end
   endtask

   task automatic test_restart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nvec++;
      if (frame_done !== 1'b0 || words_written !== '0 || bus.pix_ready !== 1'b1) begin
         nerr++; $display("FAIL restart: got fd=%b ww=%0d rdy=%b, want 0 0 1", frame_done, words_written, bus.pix_ready);
      end
   endtask

   task automatic test_grant_stall();
      logic [31:0] exp_d [4] = '{32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
      int base = wa.size();
      int acc = 0;
      logic rdy;
      bus.wr_gnt = 1'b0;
      for (int c = 0; c < 14; c++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(8'h10 + acc);
         #1 rdy = bus.pix_ready;
         @(negedge clk);
         if (rdy) acc++;
      end
      bus.pix_data = 8'(8'h10 + acc);
      #1;
      nvec++;
      if (acc !== 7 || bus.pix_ready !== 1'b0) begin
         nerr++; $display("FAIL stall_accept: got acc=%0d rdy=%b, want 7 0", acc, bus.pix_ready);
      end
      nvec++;
      if (bus.wr_req !== 1'b1 || bus.addr !== AW'(BASE) || bus.dataW !== 32'h13121110 || wa.size() !== base) begin
         nerr++; $display("FAIL stall_pending: got req=%b addr=%0d data=%h writes=%0d, want 1 %0d 13121110 0",
                          bus.wr_req, bus.addr, bus.dataW, wa.size() - base, BASE);
      end
      // Grant arrives on the cycle the 4th byte of the next group is offered.
      bus.wr_gnt = 1'b1;
      #1;
      nvec++;
      if (bus.pix_ready !== 1'b1 || bus.en !== 1'b1 || bus.we !== 1'b1) begin
         nerr++; $display("FAIL same_cycle_ready: got rdy=%b en=%b we=%b, want 1 1 1", bus.pix_ready, bus.en, bus.we);
      end
      @(negedge clk);
      acc++;
      nvec++;
      if (bus.wr_req !== 1'b1 || bus.addr !== AW'(BASE + 1) || bus.dataW !== 32'h17161514) begin
         nerr++; $display("FAIL same_cycle_load: got req=%b addr=%0d data=%h, want 1 %0d 17161514",
                          bus.wr_req, bus.addr, bus.dataW, BASE + 1);
      end
      // start pulsed in RUN must not disturb the frame.
      start = 1'b1;
      for (int c = 0; c < 40 && acc < 16; c++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(8'h10 + acc);
         #1 rdy = bus.pix_ready;
         @(negedge clk);
         if (c == 0) begin
            start = 1'b0;
            nvec++;
            if (words_written !== AW'(2)) begin nerr++; $display("FAIL start_in_run: got ww=%0d, want 2", words_written); end
         end
         if (rdy) acc++;
      end
      bus.pix_valid = 1'b0;
      for (int t = 0; t < 20 && !frame_done; t++) @(negedge clk);
      nvec++;
      if (wa.size() !== base + 4 || frame_done !== 1'b1 || words_written !== AW'(4)) begin
         nerr++; $display("FAIL stall_frame_end: got writes=%0d fd=%b ww=%0d, want 4 1 4", wa.size() - base, frame_done, words_written);
      end else begin
         for (int i = 0; i < 4; i++) begin
            nvec++;
            if (wa[base+i] !== AW'(BASE + i) || wd[base+i] !== exp_d[i]) begin
               nerr++; $display("FAIL stall_word%0d: got %0d/%h, want %0d/%h", i, wa[base+i], wd[base+i], BASE + i, exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      int base;
      int rdy = 0;
      start = 1'b1; bus.wr_gnt = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(8'ha0 + i);
         @(negedge clk);
      end
      bus.pix_valid = 1'b0;
      base = wa.size();
      bus.wr_gnt = 1'b1;
      #1;
      nvec++;
      if (bus.en !== 1'b1 || bus.dataW !== 32'ha3a2a1a0) begin
         nerr++; $display("FAIL pre_reset_commit: got en=%b data=%h, want 1 a3a2a1a0", bus.en, bus.dataW);
      end
      #2 reset = 1'b0;
      #1;
      nvec++;
      if ({bus.pix_ready, bus.wr_req, bus.en, bus.we, bus.addr, bus.dataW, words_written, frame_done} !== '0) begin
         nerr++; $display("FAIL async_reset: got rdy=%b req=%b en=%b we=%b addr=%0h data=%0h ww=%0d fd=%b, want all 0",
                          bus.pix_ready, bus.wr_req, bus.en, bus.we, bus.addr, bus.dataW, words_written, frame_done);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'hbb;
         #1 if (bus.pix_ready !== 1'b0) rdy++;
         @(negedge clk);
      end
      bus.pix_valid = 1'b0;
      nvec++;
      if (wa.size() !== base || rdy !== 0 || words_written !== '0) begin
         nerr++; $display("FAIL post_reset_quiet: got writes=%0d rdy_cycles=%0d ww=%0d, want 0 0 0", wa.size() - base, rdy, words_written);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.pix_valid = 1'b0; bus.pix_data = 8'h00; bus.wr_gnt = 1'b0;
      test_reset();
      test_full_rate();
      test_done_ignores();
      test_restart();
      test_grant_stall();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
